// File: rtl/proc_unit_gen.sv
// proc_unit_gen: parametrised processor datapath with NUM_REGS general registers,
// PC, IR, address register, Y operand register, two bus multiplexers, a carry-chain
// ALU and a four-bit status register (Z, C, N, V). It contains no control logic.
// The external controller drives every load enable and mux select.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset (clears all storage)
//   mem_word       memory read data (Bus_2 source 2)
//   Load_Reg       per-register load enables, bit i loads R[i] from Bus_2
//   Load_PC        PC <= Bus_2 (has priority over Inc_PC)
//   Inc_PC         PC <= PC + 1, modulo 2^DATA_W
//   Load_IR        IR <= Bus_2
//   Load_Add_R     address register <= Bus_2
//   Load_Reg_Y     Y <= Bus_2
//   Load_Flags     {Z,C,N,V} <= ALU flags
//   Sel_Bus_1_Mux  Bus_1 select: R[sel] if sel < NUM_REGS, PC if sel == NUM_REGS, else 0
//   Sel_Bus_2_Mux  Bus_2 select: 0 ALU, 1 Bus_1, 2 mem_word, 3 zero
//   instruction    IR contents
//   address        address register contents
//   Bus_1          Bus_1 value
//   Zflag..Vflag   registered status flags

// Generic clear-on-reset load register. It is used for each general register and
// for IR, address and Y.
module proc_unit_gen_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    q <= '0;
      else if (en) q <= d;
   end
endmodule

module proc_unit_gen #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4,
   parameter int SEL1_W   = $clog2(NUM_REGS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   mem_word,
   input  logic [NUM_REGS-1:0] Load_Reg,
   input  logic                Load_PC,
   input  logic                Inc_PC,
   input  logic                Load_IR,
   input  logic                Load_Add_R,
   input  logic                Load_Reg_Y,
   input  logic                Load_Flags,
   input  logic [SEL1_W-1:0]   Sel_Bus_1_Mux,
   input  logic [1:0]          Sel_Bus_2_Mux,
   output logic [DATA_W-1:0]   instruction,
   output logic [DATA_W-1:0]   address,
   output logic [DATA_W-1:0]   Bus_1,
   output logic                Zflag,
   output logic                Cflag,
   output logic                Nflag,
   output logic                Vflag
);
   localparam int MSB = DATA_W - 1;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_AND = 4'd3,
      OP_NOT = 4'd4,
      OP_ADC = 4'd5,
      OP_SBB = 4'd6,
      OP_SHL = 4'd7,
      OP_SHR = 4'd8,
      OP_CMP = 4'd9
   } op_t;

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic [DATA_W-1:0] pc, y_reg, bus_2;
   logic [DATA_W-1:0] alu_res, flag_res;
   logic              c_nxt, v_nxt;
   logic [DATA_W:0]   add_w, sub_w;
   logic              cin, v_add, v_sub;
   op_t               opcode;

   // ---------------- storage ----------------
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      proc_unit_gen_reg #(.W(DATA_W)) u_r (
         .clk (clk), .rst (rst), .en (Load_Reg[i]), .d (bus_2), .q (regs[i])
      );
   end

   proc_unit_gen_reg #(.W(DATA_W)) u_ir (
      .clk (clk), .rst (rst), .en (Load_IR), .d (bus_2), .q (instruction)
   );
   proc_unit_gen_reg #(.W(DATA_W)) u_ar (
      .clk (clk), .rst (rst), .en (Load_Add_R), .d (bus_2), .q (address)
   );
   proc_unit_gen_reg #(.W(DATA_W)) u_y (
      .clk (clk), .rst (rst), .en (Load_Reg_Y), .d (bus_2), .q (y_reg)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         pc <= '0;
      else if (Load_PC) pc <= bus_2;
      else if (Inc_PC)  pc <= pc + DATA_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         {Zflag, Cflag, Nflag, Vflag} <= 4'b0000;
      end else if (Load_Flags) begin
         Zflag <= (flag_res == '0);
         Cflag <= c_nxt;
         Nflag <= flag_res[MSB];
         Vflag <= v_nxt;
      end
   end

   // ---------------- bus multiplexers ----------------
   // Compare per entry rather than indexing, because the select is wider than a register index.
   always_comb begin
      Bus_1 = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (Sel_Bus_1_Mux == SEL1_W'(i)) Bus_1 = regs[i];
      if (Sel_Bus_1_Mux == SEL1_W'(NUM_REGS)) Bus_1 = pc;
   end

   always_comb begin
      case (Sel_Bus_2_Mux)
         2'd0:    bus_2 = alu_res;
         2'd1:    bus_2 = Bus_1;
         2'd2:    bus_2 = mem_word;
         default: bus_2 = '0;
      endcase
   end

   // ---------------- ALU: A = Y, B = Bus_1 ----------------
   assign opcode = op_t'(instruction[MSB -: 4]);

   // The carry-in is the pre-edge Cflag. A flag load in the same cycle replaces it after the edge.
   assign cin   = ((opcode == OP_ADC) || (opcode == OP_SBB)) ? Cflag : 1'b0;
   assign add_w = {1'b0, y_reg} + {1'b0, Bus_1} + {{DATA_W{1'b0}}, cin};
   // Bit DATA_W of the difference is the borrow, set when A < B + cin.
   assign sub_w = {1'b0, y_reg} - {1'b0, Bus_1} - {{DATA_W{1'b0}}, cin};
   assign v_add = (y_reg[MSB] == Bus_1[MSB]) && (add_w[MSB] != y_reg[MSB]);
   assign v_sub = (y_reg[MSB] != Bus_1[MSB]) && (sub_w[MSB] != y_reg[MSB]);

   always_comb begin
      alu_res  = Bus_1;
      flag_res = Bus_1;
      c_nxt    = 1'b0;
      v_nxt    = 1'b0;
      case (opcode)
         OP_ADD, OP_ADC: begin
            alu_res  = add_w[MSB:0];
            flag_res = add_w[MSB:0];
            c_nxt    = add_w[DATA_W];
            v_nxt    = v_add;
         end
         OP_SUB, OP_SBB: begin
            alu_res  = sub_w[MSB:0];
            flag_res = sub_w[MSB:0];
            c_nxt    = sub_w[DATA_W];
            v_nxt    = v_sub;
         end
         OP_AND: begin
            alu_res  = y_reg & Bus_1;
            flag_res = y_reg & Bus_1;
         end
         OP_NOT: begin
            alu_res  = ~Bus_1;
            flag_res = ~Bus_1;
         end
         OP_SHL: begin
            alu_res  = {Bus_1[MSB-1:0], 1'b0};
            flag_res = {Bus_1[MSB-1:0], 1'b0};
            c_nxt    = Bus_1[MSB];
         end
         OP_SHR: begin
            alu_res  = {1'b0, Bus_1[MSB:1]};
            flag_res = {1'b0, Bus_1[MSB:1]};
            c_nxt    = Bus_1[0];
         end
         // CMP passes B through and takes its flags from the subtraction.
         OP_CMP: begin
            flag_res = sub_w[MSB:0];
            c_nxt    = sub_w[DATA_W];
            v_nxt    = v_sub;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_proc_unit_gen.sv
// Bench for proc_unit_gen. It has an 8-bit/4-register instance with directed and
// randomized stimulus, checked against an arithmetic reference model. It also has a
// 16-bit/8-register instance for the parametrisation cases.
module tb_proc_unit_gen;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 8-bit instance
   logic [7:0] a_mem, a_ir, a_ar, a_bus1;
   logic [3:0] a_ld;
   logic       a_lpc, a_ipc, a_lir, a_lar, a_ly, a_lf;
   logic [2:0] a_s1;
   logic [1:0] a_s2;
   logic       a_z, a_c, a_n, a_v;

   proc_unit_gen u_a (
      .clk (clk), .rst (rst), .mem_word (a_mem), .Load_Reg (a_ld),
      .Load_PC (a_lpc), .Inc_PC (a_ipc), .Load_IR (a_lir), .Load_Add_R (a_lar),
      .Load_Reg_Y (a_ly), .Load_Flags (a_lf), .Sel_Bus_1_Mux (a_s1),
      .Sel_Bus_2_Mux (a_s2), .instruction (a_ir), .address (a_ar), .Bus_1 (a_bus1),
      .Zflag (a_z), .Cflag (a_c), .Nflag (a_n), .Vflag (a_v)
   );

   // 16-bit instance
   logic [15:0] b_mem, b_ir, b_ar, b_bus1;
   logic [7:0]  b_ld;
   logic        b_lpc, b_ipc, b_lir, b_lar, b_ly, b_lf;
   logic [3:0]  b_s1;
   logic [1:0]  b_s2;
   logic        b_z, b_c, b_n, b_v;

   proc_unit_gen #(.DATA_W(16), .NUM_REGS(8)) u_b (
      .clk (clk), .rst (rst), .mem_word (b_mem), .Load_Reg (b_ld),
      .Load_PC (b_lpc), .Inc_PC (b_ipc), .Load_IR (b_lir), .Load_Add_R (b_lar),
      .Load_Reg_Y (b_ly), .Load_Flags (b_lf), .Sel_Bus_1_Mux (b_s1),
      .Sel_Bus_2_Mux (b_s2), .instruction (b_ir), .address (b_ar), .Bus_1 (b_bus1),
      .Zflag (b_z), .Cflag (b_c), .Nflag (b_n), .Vflag (b_v)
   );

   int vectors = 0;
   int errs    = 0;

   typedef struct {
      logic [3:0] ld;
      bit lpc, ipc, lir, lar, ly, lf;
      int s1, s2;
      longint mem;
   } stim_t;

   // reference model state for the 8-bit instance
   longint r[4];
   longint pc, ir, ar, y;
   bit z, c, n, v;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 4; i++) r[i] = 0;
      pc = 0; ir = 0; ar = 0; y = 0;
      {z, c, n, v} = 4'b0000;
   endtask

   function automatic longint m_bus1(input int sel);
      if (sel < 4) return r[sel];
      if (sel == 4) return pc;
      return 0;
   endfunction

   // ALU worked out with plain integer arithmetic on the signed and unsigned views.
   function automatic void alu_ref(input int op, input longint a, input longint b,
                                   input bit cin, input int w, output longint res,
                                   output bit zo, output bit co, output bit no, output bit vo);
      longint m, h, sa, sb, t, st, fr, ci;
      m  = longint'(1) << w;
      h  = m / 2;
      sa = (a >= h) ? a - m : a;
      sb = (b >= h) ? b - m : b;
      ci = (op == 5 || op == 6) ? longint'(cin) : 0;
      co = 0; vo = 0; res = b; fr = b;
      case (op)
         1, 5: begin
            t = a + b + ci; st = sa + sb + ci;
            res = t % m; fr = res; co = (t >= m); vo = (st < -h) || (st >= h);
         end
         2, 6, 9: begin
            t = a - b - ci; st = sa - sb - ci;
            fr = (t + m) % m; co = (t < 0); vo = (st < -h) || (st >= h);
            res = (op == 9) ? b : fr;
         end
         3: begin res = a & b; fr = res; end
         4: begin res = m - 1 - b; fr = res; end
         7: begin res = (b * 2) % m; fr = res; co = (b >= h); end
         8: begin res = b / 2; fr = res; co = (b % 2 == 1); end
         default: ;
      endcase
      zo = (fr == 0);
      no = (fr >= h);
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s.ld = 4'b0000; s.lpc = 0; s.ipc = 0; s.lir = 0; s.lar = 0; s.ly = 0; s.lf = 0;
      s.s1 = 0; s.s2 = 0; s.mem = 0;
      return s;
   endfunction

   task automatic step_a(input stim_t s);
      longint b1, res, bus2;
      bit nz, nc, nn, nv;
      @(negedge clk);
      a_mem = 8'(s.mem); a_ld = s.ld; a_lpc = s.lpc; a_ipc = s.ipc; a_lir = s.lir;
      a_lar = s.lar; a_ly = s.ly; a_lf = s.lf; a_s1 = 3'(s.s1); a_s2 = 2'(s.s2);
      #1;
      b1 = m_bus1(s.s1);
      chk("bus1", a_bus1, 32'(b1));
      alu_ref(int'(ir >> 4), y, b1, c, 8, res, nz, nc, nn, nv);
      case (s.s2)
         0: bus2 = res;
         1: bus2 = b1;
         2: bus2 = s.mem;
         default: bus2 = 0;
      endcase
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (s.ld[i]) r[i] = bus2;
      if (s.lpc) pc = bus2;
      else if (s.ipc) pc = (pc + 1) % 256;
      if (s.lir) ir = bus2;
      if (s.lar) ar = bus2;
      if (s.ly) y = bus2;
      if (s.lf) {z, c, n, v} = {nz, nc, nn, nv};
      chk("instruction", a_ir, 32'(ir));
      chk("address", a_ar, 32'(ar));
      chk("flags", {a_z, a_c, a_n, a_v}, {z, c, n, v});
   endtask

   task automatic load_a(input int what, input longint val);
      stim_t s;
      s = idle(); s.mem = val; s.s2 = 2;
      case (what)
         0: s.ly = 1;
         1: s.ld = 4'b0010;
         default: s.lir = 1;
      endcase
      step_a(s);
   endtask

   // Load Y, R1 and IR, then run the ALU with B = R1, capturing the result in R0 and the flags.
   task automatic exec_a(input longint yv, input longint r1v, input longint irv);
      stim_t s;
      load_a(0, yv); load_a(1, r1v); load_a(2, irv);
      s = idle(); s.s1 = 1; s.s2 = 0; s.lf = 1; s.ld = 4'b0001;
      step_a(s);
   endtask

   task automatic peek_a(input int sel, input logic [7:0] exp, input string tag);
      @(negedge clk);
      a_ld = '0; a_lpc = 0; a_ipc = 0; a_lir = 0; a_lar = 0; a_ly = 0; a_lf = 0;
      a_s1 = 3'(sel);
      #1;
      chk(tag, a_bus1, exp);
   endtask

   task automatic step_b(input logic [7:0] ld, input bit lpc, input bit ipc, input bit lir,
                         input bit lf, input logic [3:0] s1, input logic [1:0] s2,
                         input logic [15:0] mem);
      @(negedge clk);
      b_ld = ld; b_lpc = lpc; b_ipc = ipc; b_lir = lir; b_lf = lf;
      b_s1 = s1; b_s2 = s2; b_mem = mem;
      @(posedge clk);
      #1;
   endtask

   task automatic peek_b(input logic [3:0] sel, input logic [15:0] exp, input string tag);
      @(negedge clk);
      b_ld = '0; b_lpc = 0; b_ipc = 0; b_lir = 0; b_lf = 0; b_s1 = sel;
      #1;
      chk(tag, b_bus1, exp);
   endtask

   initial begin
      stim_t s;
      rst = 1'b0;
      a_mem = '0; a_ld = '0; a_lpc = 0; a_ipc = 0; a_lir = 0; a_lar = 0; a_ly = 0; a_lf = 0;
      a_s1 = '0; a_s2 = '0;
      b_mem = '0; b_ld = '0; b_lpc = 0; b_ipc = 0; b_lir = 0; b_lar = 0; b_ly = 0; b_lf = 0;
      b_s1 = '0; b_s2 = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ir", a_ir, 8'h00);
      chk("rst_ar", a_ar, 8'h00);
      chk("rst_flags", {a_z, a_c, a_n, a_v}, 4'b0000);
      @(negedge clk) rst = 1'b1;

      // register file: two registers written at once
      s = idle(); s.ld = 4'b0101; s.mem = 8'h3C; s.s2 = 2; step_a(s);
      peek_a(0, 8'h3C, "r0_multi");
      peek_a(1, 8'h00, "r1_untouched");
      peek_a(2, 8'h3C, "r2_multi");
      peek_a(3, 8'h00, "r3_untouched");

      // PC load, wrap, and load-over-increment priority
      s = idle(); s.lpc = 1; s.mem = 8'hFF; s.s2 = 2; step_a(s);
      peek_a(4, 8'hFF, "pc_load");
      s = idle(); s.ipc = 1; step_a(s);
      peek_a(4, 8'h00, "pc_wrap");
      s = idle(); s.lpc = 1; s.ipc = 1; s.mem = 8'h40; s.s2 = 2; step_a(s);
      peek_a(4, 8'h40, "pc_priority");
      peek_a(7, 8'h00, "bus1_sel7");
      peek_a(5, 8'h00, "bus1_sel5");

      // ADD then ADC consuming the carry
      exec_a(8'hFF, 8'h01, 8'h10);
      chk("add_flags", {a_z, a_c, a_n, a_v}, 4'b1100);
      peek_a(0, 8'h00, "add_res");
      exec_a(8'h00, 8'h00, 8'h50);
      chk("adc_flags", {a_z, a_c, a_n, a_v}, 4'b0000);
      peek_a(0, 8'h01, "adc_res");

      // signed overflow, borrow, compare
      exec_a(8'h7F, 8'h01, 8'h10);
      chk("ovf_flags", {a_z, a_c, a_n, a_v}, 4'b0011);
      peek_a(0, 8'h80, "ovf_res");
      exec_a(8'h00, 8'h01, 8'h20);
      chk("sub_flags", {a_z, a_c, a_n, a_v}, 4'b0110);
      peek_a(0, 8'hFF, "sub_res");
      exec_a(8'h05, 8'h05, 8'h90);
      chk("cmp_flags", {a_z, a_c, a_n, a_v}, 4'b1000);
      peek_a(0, 8'h05, "cmp_bus2");

      // a register that is both Bus_1 source and destination (SHL R0 -> R0)
      load_a(2, 8'h70);
      s = idle(); s.s1 = 0; s.s2 = 0; s.ld = 4'b0001; step_a(s);
      peek_a(0, 8'h0A, "shl_self");
      s = idle(); s.lar = 1; s.mem = 8'h5A; s.s2 = 2; step_a(s);

      // asynchronous reset between edges while loads are pending
      @(negedge clk);
      a_ld = 4'hF; a_lpc = 1; a_lir = 1; a_lar = 1; a_ly = 1; a_lf = 1;
      a_mem = 8'hA5; a_s2 = 2'd2; a_s1 = 3'd0;
      #2 rst = 1'b0;
      #1;
      chk("arst_ir", a_ir, 8'h00);
      chk("arst_ar", a_ar, 8'h00);
      chk("arst_flags", {a_z, a_c, a_n, a_v}, 4'b0000);
      chk("arst_r0", a_bus1, 8'h00);
      a_s1 = 3'd4;
      #1 chk("arst_pc", a_bus1, 8'h00);
      @(posedge clk);
      #1;
      chk("rst_hold_ir", a_ir, 8'h00);
      chk("rst_hold_pc", a_bus1, 8'h00);
      @(negedge clk);
      a_ld = '0; a_lpc = 0; a_lir = 0; a_lar = 0; a_ly = 0; a_lf = 0;
      rst = 1'b1;
      m_reset();

      // randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         s = idle();
         s.ld  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         s.lpc = ($urandom_range(0, 5) == 0);
         s.ipc = ($urandom_range(0, 2) == 0);
         s.lir = ($urandom_range(0, 3) == 0);
         s.lar = ($urandom_range(0, 4) == 0);
         s.ly  = ($urandom_range(0, 3) == 0);
         s.lf  = ($urandom_range(0, 1) == 0);
         s.s1  = int'($urandom_range(0, 7));
         s.s2  = int'($urandom_range(0, 3));
         s.mem = longint'($urandom_range(0, 255));
         step_a(s);
      end

      // 16-bit / 8-register instance
      step_b(8'h08, 0, 0, 0, 0, 4'd0, 2'd2, 16'h8001);
      step_b(8'h00, 0, 0, 1, 0, 4'd0, 2'd2, 16'h7000);
      chk("w16_ir", b_ir, 16'h7000);
      step_b(8'h01, 0, 0, 0, 1, 4'd3, 2'd0, 16'h0000);
      chk("w16_shl_flags", {b_z, b_c, b_n, b_v}, 4'b0100);
      peek_b(4'd0, 16'h0002, "w16_shl_res");
      peek_b(4'd3, 16'h8001, "w16_r3");
      step_b(8'h00, 1, 0, 0, 0, 4'd0, 2'd2, 16'hFFFF);
      peek_b(4'd8, 16'hFFFF, "w16_pc_load");
      step_b(8'h00, 0, 1, 0, 0, 4'd0, 2'd0, 16'h0000);
      peek_b(4'd8, 16'h0000, "w16_pc_wrap");
      peek_b(4'd15, 16'h0000, "w16_sel15");
      chk("w16_ar", b_ar, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/proc_unit_gen.md
Name: proc_unit_gen

Overview:
- Parametrised successor to the 8-bit, four-register SPM datapath.
- Contains:
  - a NUM_REGS general register file
  - PC, IR, address register, Y operand register
  - two bus multiplexers
  - an ALU with carry-chain ops
  - a four-bit status register (Z, C, N, V) replacing the single zero flag
- Purely a datapath; the external controller drives every load/select. It sits between instruction/data memory and the control FSM.

Parameters:
- DATA_W, 8, datapath/bus/address width; legal range 8..32.
- NUM_REGS, 4, number of general registers; legal range 2..16.
- SEL1_W, $clog2(NUM_REGS+1), width of the Bus_1 select (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- mem_word  input  DATA_W  memory read data
- Load_Reg  input  NUM_REGS  per-register load enables (bit i loads Ri)
- Load_PC  input  1  PC <= Bus_2
- Inc_PC  input  1  PC <= PC+1
- Load_IR  input  1  IR <= Bus_2
- Load_Add_R  input  1  address register <= Bus_2
- Load_Reg_Y  input  1  Y <= Bus_2
- Load_Flags  input  1  {Z,C,N,V} <= ALU flags
- Sel_Bus_1_Mux  input  SEL1_W  Bus_1 source select
- Sel_Bus_2_Mux  input  2  Bus_2 source select
- instruction  output  DATA_W  IR contents
- address  output  DATA_W  address register contents
- Bus_1  output  DATA_W  Bus_1 value
- Zflag  output  1  registered zero flag
- Cflag  output  1  registered carry/borrow flag
- Nflag  output  1  registered negative flag (MSB)
- Vflag  output  1  registered signed overflow flag

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - all registers, PC, IR, address, Y and all four flags clear to 0.
  - Loads are ignored while rst=0; normal operation resumes on the first rising edge after release.
  - Reset asserted mid-operation discards any pending load.
- Bus_1 (combinational):
  - Sel_Bus_1_Mux < NUM_REGS selects R[sel].
  - == NUM_REGS selects PC.
  - > NUM_REGS drives 0.
- Bus_2 (combinational) by Sel_Bus_2_Mux: 0 = ALU result, 1 = Bus_1, 2 = mem_word, 3 = all-zeros.
- All storage updates on the rising clk edge; each load has single-cycle latency (value visible on the output the cycle after the enable is sampled).
- Multiple Load_Reg bits set: every selected register captures the same Bus_2 value.
- A register may be both a Bus_1 source and a load destination in the same cycle; it captures the pre-edge combinational value (no loop, no hazard).
- PC:
  - Load_PC has priority over Inc_PC.
  - Increment is modulo 2^DATA_W: all-ones -> 0, with no flag effect.
- ALU:
  - opcode = instruction[DATA_W-1:DATA_W-4]; A = Y, B = Bus_1.
  - 0 NOP: result = B, C=0, V=0.
  - 1 ADD: A+B.
  - 2 SUB: A-B; C = borrow, i.e. 1 when A<B unsigned.
  - 3 AND: A&B, C=0, V=0.
  - 4 NOT: ~B, C=0, V=0.
  - 5 ADC: A+B+Cflag.
  - 6 SBB: A-B-Cflag.
  - 7 SHL: B<<1, C = B[MSB], V=0.
  - 8 SHR: B>>1 logical, C = B[0], V=0.
  - 9 CMP: result = B (bus unaffected), flags as SUB.
  - 10..15: as NOP.
- Arithmetic width and flag rules:
  - Computed at DATA_W+1 bits; C = bit DATA_W; result truncated to DATA_W.
  - V = signed overflow for ADD/ADC/SUB/SBB/CMP.
  - Z = (flag result == 0), where the flag result is the truncated arithmetic result for CMP, otherwise the ALU result.
  - N = MSB of the flag result.
- Flags update only when Load_Flags=1. ADC/SBB use the registered Cflag sampled before the edge; Load_Flags in the same cycle replaces it afterwards.

Test Plan:
- Reset: drive registers non-zero, pull rst low between edges -> all outputs 0 immediately, before the next clk edge.
- Load/increment: Load_PC with mem_word=0xFF, then Inc_PC -> PC=0x00. Assert Load_PC (Bus_2=0x40) together with Inc_PC -> PC=0x40.
- Register file and Bus_1: NUM_REGS=4; Load_Reg=4'b0101 with mem_word=0x3C -> R0=R2=0x3C, R1=R3=0. Sel_Bus_1_Mux=4 -> Bus_1=PC; sel=7 -> Bus_1=0.
- ADD/ADC chain, DATA_W=8: Y=0xFF, R1=0x01, IR opcode 1, Load_Flags -> result 0x00, Z=1, C=1, N=0, V=0. Then opcode 5 with Y=0x00, R1=0x00 -> result 0x01, C=0, Z=0.
- Signed overflow: Y=0x7F, B=0x01, ADD -> 0x80, N=1, V=1, C=0. SUB Y=0x00, B=0x01 -> 0xFF, C=1, N=1, V=0. CMP Y=0x05, B=0x05 -> Z=1, Bus_2(ALU)=0x05.
- Parametrisation: DATA_W=16, NUM_REGS=8; SHL of 0x8001 -> 0x0002, C=1. PC wraps 0xFFFF -> 0x0000. Sel_Bus_1_Mux=8 selects PC.
